stream_arb_rr: RTL



---
 rtl/stream_arb_rr.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stream_arb_rr.sv
// Round-robin burst arbiter: NumCh requesters share one stream sink, one burst per grant.
// Latency: one dead IDLE cycle per grant, then data passes combinationally from the granted channel.
// Backpressure: dout_ready is routed to the granted channel only; with STREAM_ARB_FREE_GATE_EN a grant also waits for dout_free >= MaxBurst.
module stream_arb_rr #(
    parameter int NumCh    = 4,
    parameter int Width    = 8,
    parameter int MaxBurst = 16,
    parameter int FreeBits = 11,
    localparam int ChW     = $clog2(NumCh)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NumCh-1:0]       din_valid,
    output logic [NumCh-1:0]       din_ready,
    input  logic [NumCh*Width-1:0] din_data,
    input  logic [NumCh-1:0]       din_last,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [Width-1:0]       dout_data,
    output logic                   dout_last,
    output logic [ChW-1:0]         dout_chan
`ifdef STREAM_ARB_FREE_GATE_EN
    ,
    input  logic [FreeBits-1:0]    dout_free
`endif
);

    // A one-beat burst still needs a one-bit counter to keep the compare well formed.
    localparam int CntW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

    if (NumCh < 2 || NumCh > 16 || MaxBurst < 1 || MaxBurst > 256 || FreeBits < 1) begin : g_param_err
        $error("stream_arb_rr: parameter out of range");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    logic [ChW-1:0]    ptr;
    logic [ChW-1:0]    grant;
    logic [CntW-1:0]   beat_cnt;

    logic [ChW-1:0]    pick;
    logic [ChW:0]      idx;
    logic              grant_ok;
    logic              xfer;
    logic              burst_end;
    logic [Width-1:0]  data_arr [NumCh];

    for (genvar c = 0; c < NumCh; c++) begin : g_unpack
        assign data_arr[c] = din_data[c*Width +: Width];
    end

    // Round-robin search: first valid channel at ptr, ptr+1, ... wrapping modulo NumCh.
    always_comb begin
        pick = ptr;
        idx  = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (ChW+1)'(i);
            if (idx >= (ChW+1)'(NumCh)) begin
                idx = idx - (ChW+1)'(NumCh);
            end
            if (din_valid[idx[ChW-1:0]]) begin
                pick = idx[ChW-1:0];
            end
        end
    end

    // A grant may be issued only when someone requests (and, if gated, the sink can take a full burst).
`ifdef STREAM_ARB_FREE_GATE_EN
    assign grant_ok = (|din_valid) && (32'(dout_free) >= MaxBurst);
`else
    assign grant_ok = |din_valid;
`endif

    assign xfer      = (state == BURST) && din_valid[grant] && dout_ready;
    assign burst_end = xfer && (din_last[grant] || (beat_cnt == CntW'(MaxBurst - 1)));
    assign dout_chan = grant;

    // Steer the granted channel to the sink; every other requester sees ready low.
    always_comb begin
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        dout_data  = data_arr[grant];
        din_ready  = '0;
        if (state == BURST) begin
            dout_valid       = din_valid[grant];
            dout_last        = din_last[grant];
            din_ready[grant] = dout_ready;
        end
    end

    // Grant FSM: IDLE picks the next requester, BURST holds it until last beat or MaxBurst beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            grant    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        grant    <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                        ptr      <= (grant == ChW'(NumCh - 1)) ? '0 : grant + 1'b1;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
